// File: rtl/hs_width_downsizer_if.sv
// Handshake bundle for hs_width_downsizer.
//   m_valid/m_ready/m_data[/m_len] : wide-word side (into the downsizer)
//   s_valid/s_ready/s_data/s_last  : narrow-beat side (out of the downsizer)
// Modports:
//   slave  : the downsizer's view (consumes wide words, produces beats)
//   master : the surrounding environment's view (the opposite directions)
// The m_len signal exists only when DOWNSIZER_PARTIAL_EN is defined.
interface hs_width_downsizer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
);
`ifdef DOWNSIZER_PARTIAL_EN
  localparam int unsigned CW = $clog2(RATIO);
`endif

  logic                   m_valid;
  logic                   m_ready;
  logic [RATIO*WIDTH-1:0] m_data;
`ifdef DOWNSIZER_PARTIAL_EN
  logic [CW-1:0]          m_len;
`endif
  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data;
  logic                   s_last;

`ifdef DOWNSIZER_PARTIAL_EN
  modport slave (
    input  m_valid, m_data, m_len, s_ready,
    output m_ready, s_valid, s_data, s_last
  );
  modport master (
    output m_valid, m_data, m_len, s_ready,
    input  m_ready, s_valid, s_data, s_last
  );
`else
  modport slave (
    input  m_valid, m_data, s_ready,
    output m_ready, s_valid, s_data, s_last
  );
  modport master (
    output m_valid, m_data, s_ready,
    input  m_ready, s_valid, s_data, s_last
  );
`endif
endinterface

// File: rtl/hs_width_downsizer.sv
// Valid/ready width-downsizing stage: accepts one RATIO*WIDTH-bit word and emits it as
// RATIO WIDTH-bit beats, LSB slice first, flagging the final beat with s_last.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : hs_width_downsizer_if.slave
//          m_valid/m_ready/m_data[/m_len] wide input, s_valid/s_ready/s_data/s_last beats out
// Optional feature macro: DOWNSIZER_PARTIAL_EN adds m_len (beats minus one) so a word may
// emit fewer than RATIO beats; values above RATIO-1 saturate to RATIO-1.
// s_valid, s_data and s_last come straight from registers; m_ready is combinational from
// registered state and s_ready only, so there is no m_valid -> s_valid path.
module hs_width_downsizer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hs_width_downsizer_if.slave   bus
);
  localparam int unsigned CW = $clog2(RATIO);
  localparam logic [CW-1:0] LastFull = CW'(RATIO - 1);

  typedef enum logic {StEmpty, StSend} state_e;

  state_e                      state_q, state_d;
  logic [RATIO-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]               beat_q, beat_d;
  logic [CW-1:0]               last_idx_q, last_idx_d;
  logic [WIDTH-1:0]            s_data_q, s_data_d;
  logic                        s_last_q, s_last_d;
  logic [CW-1:0]               load_last_idx;
  logic                        s_valid;
  logic                        beat_fire;
  logic                        m_ready;
  logic                        word_accept;

`ifdef DOWNSIZER_PARTIAL_EN
  assign load_last_idx = (bus.m_len > LastFull) ? LastFull : bus.m_len;
`else
  assign load_last_idx = LastFull;
`endif

  assign s_valid     = (state_q == StSend);
  assign beat_fire   = s_valid & bus.s_ready;
  // Free when empty, or when the final beat leaves this cycle (back-to-back words).
  assign m_ready     = ~rst & ((state_q == StEmpty) | (beat_fire & s_last_q));
  assign word_accept = bus.m_valid & m_ready;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    beat_d     = beat_q;
    last_idx_d = last_idx_q;
    s_data_d   = s_data_q;
    s_last_d   = s_last_q;

    if (beat_fire) begin
      if (s_last_q) begin
        state_d  = StEmpty;
        s_last_d = 1'b0;
      end else begin
        beat_d   = beat_q + CW'(1);
        s_data_d = hold_q[beat_d];
        s_last_d = (beat_d == last_idx_q);
      end
    end

    // A new word overrides the completion above when both happen in one cycle.
    if (word_accept) begin
      state_d    = StSend;
      hold_d     = bus.m_data;
      beat_d     = '0;
      last_idx_d = load_last_idx;
      s_data_d   = bus.m_data[WIDTH-1:0];
      s_last_d   = (load_last_idx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      hold_q     <= '0;
      beat_q     <= '0;
      last_idx_q <= LastFull;
      s_data_q   <= '0;
      s_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      beat_q     <= beat_d;
      last_idx_q <= last_idx_d;
      s_data_q   <= s_data_d;
      s_last_q   <= s_last_d;
    end
  end

  assign bus.m_ready = m_ready;
  assign bus.s_valid = s_valid;
  assign bus.s_data  = s_data_q;
  assign bus.s_last  = s_last_q;
endmodule

// File: doc/hs_width_downsizer.md
# hs_width_downsizer

Valid/ready width-converting stage that accepts one wide word of RATIO×WIDTH bits from the upstream source and emits it as RATIO consecutive WIDTH-bit beats, LSB slice first. It sits directly upstream of the backward-registered slice and drives that slice's master-side valid/ready/data inputs. It also flags the final beat of each word.

## Interface
- WIDTH, 8, narrow beat width in bits (≥1)
- RATIO, 4, beats per wide word (≥2)
- CW, $clog2(RATIO), beat-index width (derived; not to be overridden)

- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous reset, active-high
- m_valid  input  1  upstream wide word valid
- m_ready  output  1  stage can accept a wide word this cycle
- m_data  input  RATIO*WIDTH  wide word
- m_len  input  CW  beats minus one (present only with DOWNSIZER_PARTIAL_EN)
- s_valid  output  1  narrow beat valid, registered
- s_ready  input  1  downstream accepts beat
- s_data  output  WIDTH  narrow beat, registered
- s_last  output  1  high on final beat of current word, registered

## Operation
- Holding register (RATIO×WIDTH), beat counter `beat` (CW bits), end index `last_idx` (CW bits), two states: EMPTY, SEND.
- EMPTY: s_valid=0; m_ready=1. On m_valid: load holding register, beat←0, last_idx←RATIO-1 (or m_len, see Configuration), go to SEND.
- SEND: s_valid=1, s_data=hold[beat*WIDTH +: WIDTH], s_last=(beat==last_idx).
  - s_ready=0: all outputs hold stable (no change to data, last, valid).
  - s_ready=1, not last: beat←beat+1.
  - s_ready=1, last: word complete. m_ready=1 this cycle; if m_valid also high, load new word, beat←0, stay SEND (back-to-back, no bubble); else go EMPTY.
- m_ready = (state==EMPTY) | (s_valid & s_ready & s_last); combinational from registered state and s_ready; forced 0 while rst=1.
- m_data is sampled only on the m_valid&m_ready cycle; changes at other times are ignored.
- Beat order fixed LSB-first: beat k = m_data[k*WIDTH +: WIDTH].
- Beat counter never exceeds last_idx; no wrap occurs because counter is reloaded on every word accept.

## Timing
- Reset (rst=1 at a clock edge): state←EMPTY, s_valid=0, s_last=0, s_data=0, beat=0, holding register=0. m_ready=0 during reset, 1 in the first cycle after release.
- Reset mid-word: remaining beats are discarded; s_valid=0 from the following cycle; no partial word is resumed.
- Latency: word accepted at edge N → first beat visible on s_valid/s_data after edge N, i.e. in cycle N+1.
- Throughput: with s_ready held high and m_valid held high, one beat per cycle, RATIO cycles per word, zero idle cycles between words.
- Once s_valid rises it stays high until a beat is accepted; s_data/s_last are stable while s_valid&!s_ready.
- m_ready depends combinationally on s_ready (only in last-beat case); no combinational path from m_valid to s_valid.
- Simultaneous accept of last beat and new word in same cycle is required behaviour, not an error.

## Configuration
- DOWNSIZER_PARTIAL_EN defined: m_len port present; on word accept last_idx←min(m_len, RATIO-1) (with CW bits, m_len is always ≤2^CW-1; values ≥RATIO saturate to RATIO-1); word emits last_idx+1 beats, upper slices dropped.
- DOWNSIZER_PARTIAL_EN undefined: no m_len port; last_idx is constant RATIO-1; every word emits exactly RATIO beats.

## Test plan
- Basic: WIDTH=8, RATIO=4, s_ready=1, single word 0x44332211 → s_data 0x11,0x22,0x33,0x44 in cycles N+1..N+4, s_last only with 0x44, m_ready low for cycles N+1..N+3.
- Back-to-back: words 0x44332211 then 0xDDCCBBAA with m_valid held → 8 consecutive valid beats, no gap, second word accepted in same cycle 0x44 is taken.
- Backpressure: s_ready low for 3 cycles during beat 0x22 → s_data stays 0x22, s_valid stays 1, s_last 0, then sequence resumes 0x33,0x44.
- Reset mid-word: assert rst after beat 0x22 accepted → next cycle s_valid=0, s_last=0, s_data=0; after release m_ready=1, no 0x33/0x44 emitted.
- Partial (DOWNSIZER_PARTIAL_EN, RATIO=4): m_len=1, word 0x44332211 → beats 0x11, 0x22(s_last=1) only; m_len=3 gives full 4 beats.
- Random valid/ready toggling, 1000 words vs. scoreboard → beat stream equals LSB-first split of accepted words, no loss or duplication.
